// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready sequencer that drives a combinational ALU and returns its result with flags.
// Latency: result valid ISSUE_WAIT cycles after accept; single transaction in flight, min period ISSUE_WAIT+2.
// Backpressure: result held stable until rsp_ready; cmd_ready low while busy. Optional ALU_ISSUE_CHAIN_EN adds a result accumulator.
module alu_issue_ctrl #(
    parameter int ISSUE_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic       cmd_chain,
    output logic [3:0] alu_sel,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [7:0] alu_y,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_zero,
    output logic       rsp_neg,
    output logic [7:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(ISSUE_WAIT - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic       w_accept;
    logic       w_capture;
    logic       w_done;
    logic [3:0] r_cnt;
    logic [3:0] r_alu_sel;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [7:0] r_rsp_data;
    logic       r_rsp_zero;
    logic       r_rsp_neg;
    logic [7:0] r_op_count;
    logic [3:0] w_opa;

`ifdef ALU_ISSUE_CHAIN_EN
    logic [7:0] r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 8'h00;
        end else if (w_capture) begin
            r_acc <= alu_y;
        end
    end

    assign w_opa = cmd_chain ? r_acc[3:0] : cmd_a;
`else
    logic w_unused_chain;
    assign w_unused_chain = cmd_chain;
    assign w_opa          = cmd_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_cnt == LP_LAST) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Flags are computed from the value being captured so they always match rsp_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            r_alu_sel  <= 4'd0;
            r_alu_a    <= 4'd0;
            r_alu_b    <= 4'd0;
            r_rsp_data <= 8'h00;
            r_rsp_zero <= 1'b0;
            r_rsp_neg  <= 1'b0;
            r_op_count <= 8'd0;
        end else begin
            if (w_accept) begin
                r_alu_sel <= cmd_op;
                r_alu_a   <= w_opa;
                r_alu_b   <= cmd_b;
                r_cnt     <= 4'd0;
            end else if (r_state == S_ISSUE) begin
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_capture) begin
                r_rsp_data <= alu_y;
                r_rsp_zero <= (alu_y == 8'h00);
                r_rsp_neg  <= alu_y[7];
            end
            if (w_done) begin
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign alu_sel   = r_alu_sel;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_neg   = r_rsp_neg;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: behavioural ALU, queue scoreboard, decoupled response monitor.
module tb_alu_issue_ctrl;

    localparam int IW = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [3:0] cmd_a = 4'd0;
    logic [3:0] cmd_b = 4'd0;
    logic       cmd_chain = 1'b0;
    logic [3:0] alu_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [7:0] alu_y;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       rsp_neg;
    logic [7:0] op_count;

    typedef struct {
        logic [7:0] d;
        logic       z;
        logic       n;
        logic [7:0] cnt;
        int         acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_cnt = 0;
    logic [7:0] model_acc = 8'h00;
    logic rand_ready = 1'b0;
    logic bp_req = 1'b0;
    logic mon_pend = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment ALU: 4-bit signed operands, 8-bit signed result; codes 8..15 give 0/1.
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int r;
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            4'd0:    r = ia + ib;
            4'd1:    r = ia - ib;
            4'd2:    r = ia - 1;
            4'd3:    r = ia + 1;
            4'd4:    r = -ia;
            4'd5:    r = ia & ib;
            4'd6:    r = ia | ib;
            4'd7:    r = ia * ib;
            4'd8:    r = (ia == ib) ? 1 : 0;
            4'd9:    r = (ia < ib) ? 1 : 0;
            4'd10:   r = (ia > ib) ? 1 : 0;
            4'd11:   r = (ia != ib) ? 1 : 0;
            4'd12:   r = (ia == 0) ? 1 : 0;
            4'd13:   r = (ia != 0 && ib != 0) ? 1 : 0;
            4'd14:   r = (ia != 0 || ib != 0) ? 1 : 0;
            default: r = (ia >= ib) ? 1 : 0;
        endcase
        return r[7:0];
    endfunction

    assign alu_y = alu_fn(alu_sel, alu_a, alu_b);

    alu_issue_ctrl #(.ISSUE_WAIT(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_chain (cmd_chain),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero),
        .rsp_neg   (rsp_neg),
        .op_count  (op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({tag, "_rsp_zero"},  32'(rsp_zero),  32'd0);
        chk({tag, "_rsp_neg"},   32'(rsp_neg),   32'd0);
        chk({tag, "_alu_sel"},   32'(alu_sel),   32'd0);
        chk({tag, "_alu_a"},     32'(alu_a),     32'd0);
        chk({tag, "_alu_b"},     32'(alu_b),     32'd0);
        chk({tag, "_op_count"},  32'(op_count),  32'd0);
    endtask

    // Presents one command; returns 1 time unit after the accept edge.
    task automatic do_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic ch);
        int   waited;
        exp_t e;
        logic [3:0] ae;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = ch;
        waited    = 0;
        while (!cmd_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: cmd_ready still %0b after %0d cycles, expected 1", cmd_ready, waited);
            cmd_valid = 1'b0;
            return;
        end
        ae = a;
`ifdef ALU_ISSUE_CHAIN_EN
        if (ch) ae = model_acc[3:0];
`endif
        e.d       = alu_fn(op, ae, b);
        e.z       = (e.d == 8'h00);
        e.n       = e.d[7];
        model_acc = e.d;
        model_cnt = (model_cnt + 1) % 256;
        e.cnt     = 8'(model_cnt);
        e.acc_cyc = cyc + 1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 4'($urandom);
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
        cmd_chain = 1'($urandom);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((sb_q.size() != 0 || mon_pend) && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0 || mon_pend) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Response monitor: compares each presented result against the scoreboard head.
    initial begin
        exp_t       cur;
        logic       seen;
        logic [7:0] pend_cnt;
        int         bp;
        seen      = 1'b0;
        pend_cnt  = 8'd0;
        bp        = 0;
        cur.d     = 8'h00;
        cur.z     = 1'b0;
        cur.n     = 1'b0;
        cur.cnt   = 8'd0;
        cur.acc_cyc = 0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen      = 1'b0;
                mon_pend  = 1'b0;
                bp        = 0;
                rsp_ready = 1'b0;
            end else begin
                if (mon_pend) begin
                    chk("op_count_after_hs", 32'(op_count), 32'(pend_cnt));
                    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
                    chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
                    mon_pend = 1'b0;
                end
                if (rsp_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_rsp: rsp_data %0h with no command outstanding", rsp_data);
                        end else begin
                            cur = sb_q[0];
                            chk("rsp_latency", 32'(cyc - cur.acc_cyc), 32'(IW));
                        end
                        if (bp_req) begin
                            bp     = 10;
                            bp_req = 1'b0;
                        end
                    end
                    chk("rsp_data", 32'(rsp_data), 32'(cur.d));
                    chk("rsp_zero", 32'(rsp_zero), 32'(cur.z));
                    chk("rsp_neg",  32'(rsp_neg),  32'(cur.n));
                    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
                    if (bp > 0) begin
                        rsp_ready = 1'b0;
                        bp--;
                    end else if (rand_ready) begin
                        rsp_ready = 1'($urandom_range(0, 1));
                    end else begin
                        rsp_ready = 1'b1;
                    end
                    if (rsp_ready) begin
                        if (sb_q.size() != 0) void'(sb_q.pop_front());
                        pend_cnt = cur.cnt;
                        mon_pend = 1'b1;
                        seen     = 1'b0;
                    end
                end else begin
                    if (!cmd_ready && sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL idle_state: cmd_ready %0b with nothing outstanding, expected 1", cmd_ready);
                    end
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        do_cmd(4'd0, 4'd3, 4'd4, 1'b0);
        do_cmd(4'd1, 4'd2, 4'd5, 1'b0);
        do_cmd(4'd1, 4'd5, 4'd5, 1'b0);
        do_cmd(4'd7, 4'd8, 4'd8, 1'b0);
        do_cmd(4'd0, 4'd3, 4'd4, 1'b0);
        do_cmd(4'd3, 4'd0, 4'd0, 1'b1);
        drain();

        // Hold the consumer off for 10 cycles while a second command waits.
        bp_req = 1'b1;
        do_cmd(4'd0, 4'd7, 4'd7, 1'b0);
        do_cmd(4'd8, 4'd2, 4'd2, 1'b0);
        drain();

        do_cmd(4'd0, 4'd1, 4'd2, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        model_cnt = 0;
        model_acc = 8'h00;
        #1;
        check_reset_values("mid_issue_reset");
        repeat (3) begin
            @(negedge clk);
            chk("rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;

        do_cmd(4'd0, 4'd3, 4'd4, 1'b0);
        for (int i = 0; i < 255; i++) begin
            do_cmd(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        drain();
        chk("count_wrap", 32'(op_count), 32'd0);

        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_cmd(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end
        drain();
        chk("final_op_count", 32'(op_count), 32'(model_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
